fetch_unit: RTL and testbench

- Instruction fetch stage directly downstream of the program counter.
- Takes the current instruction_address from the PC, issues word reads to instruction memory over a valid/ready request channel, and collects in-order responses.
- Buffers fetched words in a small FIFO and presents them to decode with a valid/ready handshake.
- Drives pc_stall back to the PC so the PC advances only when a request is accepted; on flush (taken branch) it discards stale responses.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types, default widths and counter sizing for the fetch stage.
package fetch_pkg;

    localparam int ADDR_WIDTH_DEF = 32;
    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic {FETCH, DRAIN} fetch_state_t;

    // A counter that must reach DEPTH itself needs one bit more than the index.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO of {address, data} pairs with clear.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int AW    = ADDR_WIDTH_DEF,
    parameter int DW    = DATA_WIDTH_DEF,
    parameter int DEPTH = 2
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_push,
    input  logic                        i_pop,
    input  logic                        i_clear,
    input  logic [AW-1:0]               i_addr,
    input  logic [DW-1:0]               i_data,
    output logic [AW-1:0]               o_addr,
    output logic [DW-1:0]               o_data,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [cnt_width(DEPTH)-1:0] o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [AW-1:0] r_addr [DEPTH];
    logic [DW-1:0] r_data [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = r_count == CW'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
    assign o_addr  = r_addr[r_rptr];
    assign o_data  = r_data[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_addr[r_wptr] <= i_addr;
                r_data[r_wptr] <= i_data;
                r_wptr         <= r_wptr + PW'(1);
            end
            if (w_pop)
                r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: credit-limited instruction fetch with in-order responses,
// a decode-side buffer, and response draining after a redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [ADDR_WIDTH-1:0] i_fetch_address,
    input  logic                  i_flush,
    output logic                  o_pc_stall,
    output logic                  o_mem_req_valid,
    input  logic                  i_mem_req_ready,
    output logic [ADDR_WIDTH-1:0] o_mem_req_address,
    input  logic                  i_mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] i_mem_resp_data,
    output logic                  o_instr_valid,
    input  logic                  i_instr_ready,
    output logic [DATA_WIDTH-1:0] o_instr_data,
    output logic [ADDR_WIDTH-1:0] o_instr_address
);

    localparam int CW = cnt_width(FIFO_DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    fetch_state_t          r_state;
    logic [CW-1:0]         r_outstanding;
    logic [CW-1:0]         r_drop_count;
    logic [CW-1:0]         w_drop_next;
    logic [CW-1:0]         w_buf_count;
    logic [CW-1:0]         w_aq_count;
    logic [ADDR_WIDTH-1:0] w_aq_addr;
    logic                  w_aq_data;
    logic                  w_aq_full;
    logic                  w_aq_empty;
    logic                  w_buf_full;
    logic                  w_buf_empty;
    logic                  w_credit;
    logic                  w_accept;
    logic                  w_resp;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_unused;

    // In-flight plus buffered words may never exceed the buffer size.
    assign w_credit          = ({1'b0, r_outstanding} + {1'b0, w_buf_count}) < DEPTH_C;
    assign o_mem_req_valid   = i_reset && r_state == FETCH && !i_flush && w_credit;
    assign o_mem_req_address = i_fetch_address;
    assign w_accept          = o_mem_req_valid && i_mem_req_ready;
    assign o_pc_stall        = !w_accept;
    assign w_resp            = i_mem_resp_valid && r_outstanding != '0;
    assign w_push            = w_resp && r_state == FETCH && !i_flush;
    assign o_instr_valid     = !w_buf_empty && !i_flush;
    assign w_pop             = o_instr_valid && i_instr_ready;
    assign w_drop_next       = r_outstanding - CW'(w_resp);
    assign w_unused          = &{1'b0, w_aq_data, w_aq_full, w_aq_empty, w_aq_count, w_buf_full};

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= FETCH;
            r_outstanding <= '0;
            r_drop_count  <= '0;
        end else begin
            r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_resp);
            if (r_state == FETCH) begin
                if (i_flush) begin
                    r_drop_count <= w_drop_next;
                    r_state      <= w_drop_next != '0 ? DRAIN : FETCH;
                end
            end else if (w_resp) begin
                r_drop_count <= r_drop_count - CW'(1);
                r_state      <= r_drop_count == CW'(1) ? FETCH : DRAIN;
            end
        end
    end

    fetch_fifo #(.AW(ADDR_WIDTH), .DW(1), .DEPTH(FIFO_DEPTH)) u_addr_q (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (w_accept),
        .i_pop   (w_push),
        .i_clear (i_flush),
        .i_addr  (i_fetch_address),
        .i_data  (1'b0),
        .o_addr  (w_aq_addr),
        .o_data  (w_aq_data),
        .o_full  (w_aq_full),
        .o_empty (w_aq_empty),
        .o_count (w_aq_count)
    );

    fetch_fifo #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_instr_buf (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (i_flush),
        .i_addr  (w_aq_addr),
        .i_data  (i_mem_resp_data),
        .o_addr  (o_instr_address),
        .o_data  (o_instr_data),
        .o_full  (w_buf_full),
        .o_empty (w_buf_empty),
        .o_count (w_buf_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench with a queue-level memory and PC model.
module tb_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        mem_req_ready = 1'b0;
    logic        mem_resp_valid = 1'b0;
    logic        instr_ready = 1'b0;
    logic [31:0] fetch_address = '0;
    logic [31:0] mem_resp_data = '0;
    logic        pc_stall;
    logic        mem_req_valid;
    logic [31:0] mem_req_address;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_address;

    fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
        .i_clock           (clk),
        .i_reset           (rst_n),
        .i_fetch_address   (fetch_address),
        .i_flush           (flush),
        .o_pc_stall        (pc_stall),
        .o_mem_req_valid   (mem_req_valid),
        .i_mem_req_ready   (mem_req_ready),
        .o_mem_req_address (mem_req_address),
        .i_mem_resp_valid  (mem_resp_valid),
        .i_mem_resp_data   (mem_resp_data),
        .o_instr_valid     (instr_valid),
        .i_instr_ready     (instr_ready),
        .o_instr_data      (instr_data),
        .o_instr_address   (instr_address)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    req_t        mq[$];
    logic [31:0] exp_q[$];
    logic [31:0] pc = 32'h10;
    logic [31:0] mon_addr;
    int          cyc = 0;
    int          n_arr = 0;
    int          lat = 1;
    int          checks = 0;
    int          failures = 0;
    int          delivered = 0;
    bit          rst_next = 1'b0;

    function automatic logic [31:0] dfun(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d: got %0h, required %0h", name, cyc, act, exp);
        end
    endtask

    // One clock of stimulus; the model says what the DUT must show before the edge
    // and then advances memory, PC and the expected-instruction queue past it.
    task automatic cycle(input bit rdy, input bit ird, input bit fl, input logic [31:0] tgt);
        bit   resp;
        bit   exp_req;
        int   stale_n;
        req_t e;
        @(negedge clk);
        cyc++;
        rst_n          = rst_next;
        resp           = mq.size() > 0 && mq[0].due <= cyc;
        mem_resp_valid = resp;
        mem_resp_data  = resp ? dfun(mq[0].addr) : 32'h0;
        mem_req_ready  = rdy;
        instr_ready    = ird;
        flush          = fl;
        if (fl) pc = tgt;
        fetch_address = pc;
        #1;
        assert (!(mem_resp_valid && mq.size() == 0)) else $error("response with nothing outstanding");
        stale_n = 0;
        foreach (mq[i]) if (mq[i].stale) stale_n++;
        exp_req = rst_n && !fl && stale_n == 0 && exp_q.size() < DEPTH;
        chk("mem_req_valid", {31'b0, mem_req_valid}, {31'b0, exp_req});
        chk("pc_stall", {31'b0, pc_stall}, {31'b0, !(exp_req && rdy)});
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, n_arr > 0 && !fl});
        if (exp_req) chk("mem_req_address", mem_req_address, pc);
        if (resp) begin
            e = mq.pop_front();
            if (!e.stale && !fl) n_arr++;
        end
        if (fl) begin
            foreach (mq[i]) mq[i].stale = 1'b1;
            exp_q.delete();
            n_arr = 0;
        end
        if (exp_req && rdy) begin
            mq.push_back('{pc, cyc + lat, 1'b0});
            exp_q.push_back(pc);
            pc++;
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL instr_unexpected cycle=%0d: got address %0h, required no instruction", cyc, instr_address);
            end else begin
                mon_addr = exp_q.pop_front();
                chk("instr_address", instr_address, mon_addr);
                chk("instr_data", instr_data, dfun(mon_addr));
                n_arr--;
                delivered++;
            end
        end
    end

    initial begin
        #1;
        chk("reset_mem_req_valid", {31'b0, mem_req_valid}, 32'h0);
        chk("reset_instr_valid", {31'b0, instr_valid}, 32'h0);
        chk("reset_pc_stall", {31'b0, pc_stall}, 32'h1);
        chk("reset_instr_data", instr_data, 32'h0);
        chk("reset_instr_address", instr_address, 32'h0);
        repeat (2) cycle(1, 1, 0, 0);
        rst_next = 1'b1;
        lat = 1;
        repeat (8) cycle(1, 1, 0, 0);
        repeat (10) cycle(1, 0, 0, 0);
        repeat (6) cycle(1, 1, 0, 0);
        lat = 3;
        repeat (6) cycle(1, 1, 0, 0);
        cycle(1, 1, 1, 32'h40);
        repeat (10) cycle(1, 1, 0, 0);
        for (int k = 0; k < 10; k++) begin
            if (mq.size() > 0 && mq[0].due <= cyc + 1 && !mq[0].stale) begin
                cycle(1, 1, 1, 32'h80);
                break;
            end
            cycle(1, 1, 0, 0);
        end
        repeat (8) cycle(1, 1, 0, 0);
        lat = 1;
        repeat (6) cycle(1, 0, 0, 0);
        #2;
        rst_n    = 1'b0;
        rst_next = 1'b0;
        #1;
        chk("async_reset_instr_valid", {31'b0, instr_valid}, 32'h0);
        chk("async_reset_mem_req_valid", {31'b0, mem_req_valid}, 32'h0);
        chk("async_reset_pc_stall", {31'b0, pc_stall}, 32'h1);
        mq.delete();
        exp_q.delete();
        n_arr = 0;
        pc    = 32'h200;
        repeat (2) cycle(1, 1, 0, 0);
        rst_next = 1'b1;
        repeat (8) cycle(1, 1, 0, 0);
        repeat (3) begin
            cycle(1, 1, 0, 0);
            cycle(0, 1, 0, 0);
            cycle(0, 1, 0, 0);
            cycle(1, 1, 0, 0);
        end
        repeat (1500) begin
            if ($urandom % 50 == 0) lat = $urandom_range(1, 4);
            cycle($urandom % 4 != 0, $urandom % 3 != 0, $urandom % 25 == 0, $urandom);
        end
        lat = 1;
        repeat (12) cycle(1, 1, 0, 0);
        chk("delivered_enough", {31'b0, delivered > 100}, 32'h1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
